// File: rtl/ping_sensor_ctrl.sv
`default_nettype none
// ping_sensor_ctrl: single-wire (PING-style) ultrasonic ranging controller; echo width in us on out_data.
// Optional macro PING_AUTO_TRIGGER_EN: re-trigger automatically every time IDLE is entered.
module ping_sensor_ctrl #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned TRIG_US     = 5,
    parameter int unsigned WAIT_MAX_US = 1000,
    parameter int unsigned ECHO_MAX_US = 20000,
    parameter int unsigned RECOVER_US  = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        busy,
    inout  wire         sig,
    output logic [31:0] out_data,
    output logic [3:0]  led
);

    localparam int unsigned DIV        = (CLK_FREQ_HZ / 1000000 > 0) ? CLK_FREQ_HZ / 1000000 : 1;
    localparam logic [31:0] DIV_LAST   = 32'(DIV - 1);
    localparam logic [31:0] TRIG_LAST  = 32'(TRIG_US - 1);
    localparam logic [31:0] WAIT_LAST  = 32'(WAIT_MAX_US - 1);
    localparam logic [31:0] ECHO_LAST  = 32'(ECHO_MAX_US - 1);
    localparam logic [31:0] RECOV_LAST = 32'(RECOVER_US - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ECHO  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_TOUT  = 3'd5;
    localparam logic [2:0] S_RECOV = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [31:0] pre_q, pre_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] out_q, out_d;
    logic        led1_q, led1_d;
    logic        led3_q, led3_d;
    logic        oe_q;
    logic        meta_q, sync_q, prev_q;
    logic        tick, rise, fall, start, change;

`ifdef PING_AUTO_TRIGGER_EN
    assign start = 1'b1 | req;
`else
    assign start = req;
`endif

    assign tick = (pre_q == DIV_LAST);
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        led1_d  = led1_q;
        led3_d  = led3_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_TRIG;
            S_TRIG:  if (tick && cnt_q == TRIG_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (rise)                              state_d = S_ECHO;
                else if (tick && cnt_q == WAIT_LAST)   state_d = S_TOUT;
            end
            S_ECHO: begin
                if (fall)                              state_d = S_DONE;
                else if (tick && cnt_q == ECHO_LAST)   state_d = S_TOUT;
            end
            S_DONE: begin
                out_d   = cnt_q;
                led1_d  = 1'b0;
                led3_d  = ~led3_q;
                state_d = S_RECOV;
            end
            S_TOUT: begin
                out_d   = 32'hFFFF_FFFF;
                led1_d  = 1'b1;
                led3_d  = ~led3_q;
                state_d = S_RECOV;
            end
            S_RECOV: if (tick && cnt_q == RECOV_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        change = (state_d != state_q);
        pre_d  = (change || tick) ? 32'd0 : pre_q + 32'd1;
        // DONE must still see the echo count, so entering it does not clear the counter
        cnt_d  = cnt_q;
        if (change && state_d != S_DONE) cnt_d = 32'd0;
        else if (tick)                   cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pre_q   <= 32'd0;
            cnt_q   <= 32'd0;
            out_q   <= 32'd0;
            led1_q  <= 1'b0;
            led3_q  <= 1'b0;
            oe_q    <= 1'b0;
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            led1_q  <= led1_d;
            led3_q  <= led3_d;
            oe_q    <= (state_d == S_TRIG);
            meta_q  <= sig;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
        end
    end

    assign sig      = oe_q ? 1'b1 : 1'bz;
    assign busy     = (state_q != S_IDLE);
    assign out_data = out_q;
    assign led      = {led3_q, sync_q, led1_q, busy};

endmodule
`default_nettype wire

// File: tb/tb_ping_sensor_ctrl.sv
`default_nettype none
// tb_ping_sensor_ctrl: randomized pings against a behavioural sensor/result model.
`timescale 1ns/1ps
module tb_ping_sensor_ctrl;

    localparam int CLK_HZ   = 4000000;
    localparam int DIV      = CLK_HZ / 1000000;
    localparam int TRIG_US  = 5;
    localparam int WAIT_MAX = 100;
    localparam int ECHO_MAX = 200;
    localparam int RECOV    = 20;
    localparam longint TOUT_VAL = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        busy;
    wire         sig;
    logic [31:0] out_data;
    logic [3:0]  led;
    logic        echo_drv = 1'b0;

    assign sig = echo_drv ? 1'b1 : 1'bz;
    pulldown (sig);

    always #5 clk = ~clk;

    ping_sensor_ctrl #(
        .CLK_FREQ_HZ(CLK_HZ),
        .TRIG_US    (TRIG_US),
        .WAIT_MAX_US(WAIT_MAX),
        .ECHO_MAX_US(ECHO_MAX),
        .RECOVER_US (RECOV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .busy    (busy),
        .sig     (sig),
        .out_data(out_data),
        .led     (led)
    );

    int checks   = 0;
    int failures = 0;
    int q_d[$];
    int q_w[$];
    int q_trig[$];
    bit sensor_active = 1'b0;
    bit led3_exp      = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        checks++;
        if (got < exp - tol || got > exp + tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
        end
    endtask

    // Sensor model: answers each trigger with the next queued (delay, width) in us.
    // delay -1 = line already high during the trigger, -2 / empty queue = silent.
    int s_n, s_d, s_w;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (sig === 1'b1 && !echo_drv) begin
                sensor_active = 1'b1;
                s_n = 0; s_d = -2; s_w = 0;
                if (q_d.size() > 0) begin
                    s_d = q_d.pop_front();
                    s_w = q_w.pop_front();
                end
                if (s_d == -1) begin
                    echo_drv = 1'b1;
                    repeat (s_w * DIV) begin @(posedge clk); #1; end
                    echo_drv = 1'b0;
                    q_trig.push_back(-1);
                end else begin
                    while (sig === 1'b1 && s_n < 100000) begin
                        s_n++;
                        @(posedge clk); #1;
                    end
                    q_trig.push_back(s_n);
                    if (s_d >= 0) begin
                        repeat (s_d * DIV) begin @(posedge clk); #1; end
                        echo_drv = 1'b1;
                        repeat (s_w * DIV) begin @(posedge clk); #1; end
                        echo_drv = 1'b0;
                    end
                end
                sensor_active = 1'b0;
            end
        end
    end

    task automatic wait_sensor_idle();
        int n;
        n = 0;
        while ((sensor_active || echo_drv) && n < 20000) begin @(negedge clk); n++; end
        if (sensor_active || echo_drv) check("sensor_idle_timeout", 1, 0, 0);
    endtask

    // One request pulse; the expected result is derived from the sensor timing alone.
    task automatic ping(input int d, input int w);
        longint exp;
        int n, t_res, tl;
        if (d != -2) begin q_d.push_back(d); q_w.push_back(w); end
        exp = (d < 0 || d > WAIT_MAX || w > ECHO_MAX) ? TOUT_VAL : longint'(w);
        @(negedge clk);
        check("idle_busy", busy, 0, 0);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("busy_latency", busy, 1, 0);
        check("led0_busy", led[0], 1, 0);
        n = 0; t_res = -1;
        while (busy && n < 20000) begin
            @(negedge clk);
            req = 1'b0;
            n++;
            if (t_res < 0 && led[3] != led3_exp) begin
                t_res = n;
                req   = 1'b1;   // request during RECOV must be dropped
            end
        end
        req = 1'b0;
        if (busy) check("busy_fall_timeout", 1, 0, 0);
        led3_exp = ~led3_exp;
        check("result", out_data, exp, (exp == TOUT_VAL) ? 0 : 1);
        check("led1_timeout", led[1], (exp == TOUT_VAL) ? 1 : 0, 0);
        check("led3_toggle", led[3], led3_exp, 0);
        check("recover_cycles", n - t_res, RECOV * DIV, 0);
        repeat (3 * DIV) @(negedge clk);
        check("no_extra_meas", busy, 0, 0);
        wait_sensor_idle();
        tl = (q_trig.size() > 0) ? q_trig.pop_front() : 0;
        if (d != -1) check("trig_cycles", tl, TRIG_US * DIV, 0);
        q_trig.delete();
    endtask

    int hw[3] = '{30, 60, 90};
    int n, kind;

    initial begin
        #2 rst = 1'b0;
        #1;
        check("rst_busy", busy, 0, 0);
        check("rst_out", out_data, 0, 0);
        check("rst_led", led, 0, 0);
        check("rst_sig", (sig === 1'b1), 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        ping(75, 100);                  // normal
        ping(-2, 0);                    // no echo
        ping(75, ECHO_MAX + 30);        // stuck high echo
        ping(20, 30);                   // good ping after stuck echo
        ping(-1, WAIT_MAX + 30);        // line high when WAIT is entered
        ping(WAIT_MAX - 3, ECHO_MAX - 3);

        // reset during TRIG releases the pin at once
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        n = 0;
        while (sig !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_trig_sig", (sig === 1'b1), 0, 0);
        check("rst_trig_busy", busy, 0, 0);
        check("rst_trig_out", out_data, 0, 0);
        led3_exp = 1'b0;
        @(negedge clk); rst = 1'b1;
        wait_sensor_idle();
        q_trig.delete();

        // reset in the middle of an echo
        ping(30, 50);
        q_d.push_back(10); q_w.push_back(100);
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        n = 0;
        while (!echo_drv && n < 5000) begin @(negedge clk); n++; end
        repeat (40 * DIV) @(negedge clk);
        check("echo_led2", led[2], 1, 0);
        check("echo_busy", busy, 1, 0);
        #2 rst = 1'b0;
        #1;
        check("rst_echo_busy", busy, 0, 0);
        check("rst_echo_out", out_data, 0, 0);
        check("rst_echo_led", led, 0, 0);
        led3_exp = 1'b0;
        @(negedge clk); rst = 1'b1;
        wait_sensor_idle();
        q_trig.delete();
        ping(20, 80);

        // req held high: back-to-back measurements, one IDLE cycle apart
        for (int i = 0; i < 3; i++) begin q_d.push_back(5); q_w.push_back(hw[i]); end
        @(negedge clk); req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!busy && n < 100) begin @(negedge clk); n++; end
            n = 0;
            while (busy && n < 20000) begin @(negedge clk); n++; end
            check("held_busy_fall", busy, 0, 0);
            if (i == 2) req = 1'b0;
            led3_exp = ~led3_exp;
            check("held_result", out_data, hw[i], 1);
            check("held_led3", led[3], led3_exp, 0);
            if (i < 2) begin
                @(negedge clk);
                check("held_gap", busy, 1, 0);
            end
        end
        repeat (4 * DIV) @(negedge clk);
        check("held_stop", busy, 0, 0);
        wait_sensor_idle();
        q_trig.delete();

        // randomized pings, kept clear of the +-2 us ambiguity at each limit
        for (int i = 0; i < 10; i++) begin
            kind = int'($urandom_range(3, 0));
            case (kind)
                0: ping(int'($urandom_range(WAIT_MAX - 3, 2)), int'($urandom_range(ECHO_MAX - 3, 1)));
                1: ping(int'($urandom_range(WAIT_MAX + 10, WAIT_MAX + 2)), int'($urandom_range(20, 1)));
                2: ping(int'($urandom_range(50, 2)), int'($urandom_range(ECHO_MAX + 10, ECHO_MAX + 2)));
                default: ping(-2, 0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
